// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide unit holding the HI/LO registers.
// MULT/MULTU/DIV/DIVU take a fixed 33-clock sequence (accept, 32 iterations, fixup).
// MTHI/MTLO write HI/LO directly in one edge without touching busy/done.
// Operands are converted to magnitudes on accept so the iteration datapath is
// purely unsigned; sign correction happens once in the fixup state.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // Two's-complement negation helpers.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  state_t      state_r, state_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        accept_s, mthi_s, mtlo_s;
  logic [4:0]  cnt_r;

  // Latched operation context.
  logic        is_div_r;
  logic        sign_a_r, sign_b_r;
  logic [31:0] opnd_r;      // multiplicand (multiply) or divisor (divide) magnitude
  logic [31:0] rs_orig_r;   // untouched dividend, returned in HI on divide by zero
  logic [63:0] acc_r;       // multiply: {partial product, multiplier}; divide: [31:0] dividend/quotient shifter
  logic [32:0] rem_r;       // divide partial remainder
  logic [31:0] hi_r, lo_r;

  // Operand decode for the accept edge.
  logic        div_op_s, signed_op_s, sign_a_s, sign_b_s;
  logic [31:0] mag_a_s, mag_b_s;

  // Iteration datapath.
  logic [32:0] mul_sum_s;
  logic [63:0] acc_mul_s;
  logic [32:0] shift_s, diff_s, rem_next_s;
  logic        ge_s;
  logic [31:0] quo_next_s;

  // Fixup datapath.
  logic [63:0] prod_fix_s;
  logic [31:0] quo_fix_s, rem_fix_s, hi_fix_s, lo_fix_s;

  // Decode signedness and operand magnitudes from the incoming request.
  always_comb begin
    div_op_s    = op[1];
    signed_op_s = ~op[0];
    sign_a_s    = signed_op_s & rs_data[31];
    sign_b_s    = signed_op_s & rt_data[31];
    if (sign_a_s) begin
      mag_a_s = neg32(rs_data);
    end else begin
      mag_a_s = rs_data;
    end
    if (sign_b_s) begin
      mag_b_s = neg32(rt_data);
    end else begin
      mag_b_s = rt_data;
    end
  end

  // One shift-add multiply step and one restoring divide step per clock.
  always_comb begin
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[63:32]} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[63:32]};
    end
    acc_mul_s = {mul_sum_s, acc_r[31:1]};

    shift_s = {rem_r[31:0], acc_r[31]};
    diff_s  = shift_s - {1'b0, opnd_r};
    // A set top remainder bit means the true shifted value already exceeds any divisor.
    ge_s    = rem_r[32] | (shift_s >= {1'b0, opnd_r});
    if (ge_s) begin
      rem_next_s = diff_s;
      quo_next_s = {acc_r[30:0], 1'b1};
    end else begin
      rem_next_s = shift_s;
      quo_next_s = {acc_r[30:0], 1'b0};
    end
  end

  // Sign correction and divide-by-zero handling for the final HI/LO write.
  always_comb begin
    if (sign_a_r ^ sign_b_r) begin
      prod_fix_s = neg64(acc_r);
      quo_fix_s  = neg32(acc_r[31:0]);
    end else begin
      prod_fix_s = acc_r;
      quo_fix_s  = acc_r[31:0];
    end
    // Remainder follows the sign of the dividend.
    if (sign_a_r) begin
      rem_fix_s = neg32(rem_r[31:0]);
    end else begin
      rem_fix_s = rem_r[31:0];
    end
    if (!is_div_r) begin
      hi_fix_s = prod_fix_s[63:32];
      lo_fix_s = prod_fix_s[31:0];
    end else if (opnd_r == 32'd0) begin
      hi_fix_s = rs_orig_r;
      lo_fix_s = 32'hFFFF_FFFF;
    end else begin
      hi_fix_s = rem_fix_s;
      lo_fix_s = quo_fix_s;
    end
  end

  // Next-state and handshake decode for the IDLE/RUN/FIX sequence.
  always_comb begin
    state_s  = state_r;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    accept_s = 1'b0;
    mthi_s   = 1'b0;
    mtlo_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              accept_s = 1'b1;
              busy_s   = 1'b1;
              state_s  = RUN;
            end
            OP_MTHI: mthi_s = 1'b1;
            OP_MTLO: mtlo_s = 1'b1;
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        busy_s = 1'b1;
        if (cnt_r == 5'd31) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX: begin
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Operand capture on accept and iteration updates during RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= 5'd0;
      is_div_r  <= 1'b0;
      sign_a_r  <= 1'b0;
      sign_b_r  <= 1'b0;
      opnd_r    <= 32'd0;
      rs_orig_r <= 32'd0;
      acc_r     <= 64'd0;
      rem_r     <= 33'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r     <= 5'd0;
            is_div_r  <= div_op_s;
            sign_a_r  <= sign_a_s;
            sign_b_r  <= sign_b_s;
            rs_orig_r <= rs_data;
            rem_r     <= 33'd0;
            if (div_op_s) begin
              opnd_r <= mag_b_s;
              acc_r  <= {32'd0, mag_a_s};
            end else begin
              opnd_r <= mag_a_s;
              acc_r  <= {32'd0, mag_b_s};
            end
          end
        end
        RUN: begin
          cnt_r <= cnt_r + 5'd1;
          if (is_div_r) begin
            acc_r <= {acc_r[63:32], quo_next_s};
            rem_r <= rem_next_s;
          end else begin
            acc_r <= acc_mul_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Architectural HI/LO: direct moves from IDLE, full results only from FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else begin
      if (mthi_s) begin
        hi_r <= rs_data;
      end else if (state_r == FIX) begin
        hi_r <= hi_fix_s;
      end
      if (mtlo_s) begin
        lo_r <= rs_data;
      end else if (state_r == FIX) begin
        lo_r <= lo_fix_s;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Architectural result of one instruction, from plain arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ch, input logic [31:0] cl,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    h  = ch;
    l  = cl;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
      end
      3'd3: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin l = a / b; h = a % b; end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: begin end
    endcase
  endfunction

  // Issue a multiply/divide at the current time and follow it through E33.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input bit poke);
    logic [31:0] nh, nl;
    model(o, a, b, exp_hi, exp_lo, nh, nl);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    step();
    check($sformatf("%s busy@E0", tag), 32'(busy), 32'd1);
    check($sformatf("%s done@E0", tag), 32'(done), 32'd0);
    start = 1'b0; op = 3'($urandom); rs_data = $urandom; rt_data = $urandom;
    for (int k = 1; k <= 33; k++) begin
      step();
      if (k < 33) begin
        check($sformatf("%s busy@E%0d", tag, k), 32'(busy), 32'd1);
        check($sformatf("%s done@E%0d", tag, k), 32'(done), 32'd0);
        check($sformatf("%s hi_hold@E%0d", tag, k), hi, exp_hi);
        check($sformatf("%s lo_hold@E%0d", tag, k), lo, exp_lo);
        if (poke && k == 10) begin
          start = 1'b1; op = 3'd3; rs_data = $urandom; rt_data = $urandom_range(1, 9);
        end
        if (poke && k == 11) start = 1'b0;
      end else begin
        check($sformatf("%s busy@E33", tag), 32'(busy), 32'd0);
        check($sformatf("%s done@E33", tag), 32'(done), 32'd1);
        check($sformatf("%s hi", tag), hi, nh);
        check($sformatf("%s lo", tag), lo, nl);
      end
    end
    exp_hi = nh;
    exp_lo = nl;
  endtask

  // MTHI/MTLO or an ignored code with start held for one edge.
  task automatic mt(input logic [2:0] o, input logic [31:0] a, input string tag);
    logic [31:0] nh, nl;
    model(o, a, 32'd0, exp_hi, exp_lo, nh, nl);
    start = 1'b1; op = o; rs_data = a; rt_data = $urandom;
    step();
    check($sformatf("%s hi", tag), hi, nh);
    check($sformatf("%s lo", tag), lo, nl);
    check($sformatf("%s busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s done", tag), 32'(done), 32'd0);
    exp_hi = nh;
    exp_lo = nl;
  endtask

  task automatic idle_chk(input string tag);
    step();
    check($sformatf("%s busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s done", tag), 32'(done), 32'd0);
    check($sformatf("%s hi", tag), hi, exp_hi);
    check($sformatf("%s lo", tag), lo, exp_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          pulses;

    reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
    step();
    step();
    reset = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);

    mt(3'd4, 32'hAAAA_5555, "mthi");
    mt(3'd5, 32'h5555_AAAA, "mtlo");
    start = 1'b0;
    idle_chk("after_mt");
    mt(3'd6, 32'h1111_2222, "op110");
    mt(3'd7, 32'h3333_4444, "op111");
    start = 1'b0;
    idle_chk("after_nop");

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0);
    idle_chk("multu_max_single_done");
    issue(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg", 1'b0);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_min_b2b", 1'b0);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7_2", 1'b0);
    issue(3'd3, 32'd7, 32'd2, "divu_7_2", 1'b0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
    issue(3'd2, 32'h1234_5678, 32'd0, "div_by0", 1'b0);
    issue(3'd3, 32'h1234_5678, 32'd0, "divu_by0", 1'b0);
    idle_chk("after_div");
    issue(3'd3, 32'd100, 32'd7, "divu_poke", 1'b1);
    idle_chk("poke_no_queue1");
    idle_chk("poke_no_queue2");

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'($urandom_range(1, 16));
        default: begin end
      endcase
      if (ro < 3'd4) begin
        issue(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro), 1'b0);
      end else begin
        mt(ro, ra, $sformatf("rand%0d_op%0d", i, ro));
        start = 1'b0;
      end
    end
    idle_chk("after_rand");

    mt(3'd4, 32'hDEAD_BEEF, "pre_reset_mthi");
    mt(3'd5, 32'hCAFE_F00D, "pre_reset_mtlo");
    start = 1'b1; op = 3'd1; rs_data = 32'h0001_0003; rt_data = 32'h0002_0005;
    step();
    start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    step();
    step();
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done) pulses++;
    end
    check("abort no_done_pulse", 32'(pulses), 32'd0);
    check("abort hi_after", hi, 32'd0);
    issue(3'd1, 32'd3, 32'd5, "multu_3x5", 1'b0);
    idle_chk("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file. It takes the two register-file read ports (rs, rt) as operands and executes MULT, MULTU, DIV and DIVU over a fixed 33-cycle sequence. It also executes MTHI and MTLO, and holds the architectural HI/LO registers that MFHI/MFLO read. A start/busy/done handshake lets the controller stall while an operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; accepted on a rising edge when busy=0.
- op  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are ignored.
- rs_data  in  32  operand A; dividend for DIV/DIVU, source for MTHI/MTLO.
- rt_data  in  32  operand B; divisor for DIV/DIVU.
- busy  out  1  high while a multiply or divide is in flight.
- done  out  1  one-cycle pulse when HI/LO take a multiply or divide result.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 with MULT/MULTU/DIV/DIVU: latch operands, clear the 5-bit iteration counter, go to RUN.
  - Signed ops latch magnitudes plus the sign of each operand. Unsigned ops latch the operands as-is with signs 0.
  - MTHI/MTLO: write rs_data into hi or lo on that edge and stay in IDLE. busy and done stay 0.
  - Codes 110 and 111: no state change.
- RUN: 32 iterations, one per clock; the counter wraps 31->0 and the FSM moves to FIX.
  - Multiply: shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first, using a 33-bit partial remainder.
- FIX: apply sign correction, write hi/lo, pulse done, return to IDLE.
  - Multiply: {hi,lo} = 64-bit product, two's-complement negated if the signs differ.
  - Divide: lo = quotient, negated if the signs differ. hi = remainder, which takes the sign of the dividend.
  - Divide by zero (rt latched as 0, signed or unsigned): hi = original rs_data, lo = 0xFFFFFFFF. No sign fixup. Same latency as a normal divide.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000. No exception.
- start while busy=1 is ignored and does not queue.
- rs_data, rt_data and op may change freely after the accept edge.
- hi/lo hold their previous values throughout RUN. There are no partial updates.

## Timing
- Reset values: FSM=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
  - Reset asserted mid-operation aborts it immediately.
  - No done pulse follows the abort, and hi/lo read 0.
- Edge numbering:
  - Accept edge is E0. busy=1 from just after E0.
  - E1..E32 are the RUN iterations.
  - E33 is FIX: hi/lo updated, done=1, busy=0.
- Result latency: 33 clocks from the accept edge. done is high for exactly the one cycle following E33.
- Back-to-back: a new start sampled at the edge after E33 (busy=0 while done=1) is accepted. The new operation's busy=1 follows that edge.
- MTHI/MTLO latency: 1 edge. The value is visible on hi/lo in the cycle after the accept edge.
- busy and done are registered outputs with no combinational path from start.

## Test plan
- Reset: assert reset mid-RUN at cycle 10 with a MULTU pending, then deassert.
  - Required: busy=0, done=0, hi=lo=0 immediately.
  - Required: no done pulse afterwards.
  - Required: the next MULTU 3*5 gives lo=15, hi=0.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF:
  - Required: busy high for 33 cycles.
  - Required: done pulses once, with hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD * 7 (-3*7):
  - Required: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - Also: MULT 0x80000000 * 0x80000000 gives hi=0x40000000, lo=0.
- Divide results:
  - DIV 0xFFFFFFF9 / 2 (-7/2) gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7 / 2 gives lo=3, hi=1.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero: DIV and DIVU with rs=0x12345678, rt=0.
  - Required: hi=0x12345678, lo=0xFFFFFFFF.
  - Required: done at E33.
- Handshake:
  - start DIVU while busy: ignored, with no change to the first result.
  - MTHI 0xAAAA5555 then MTLO 0x5555AAAA in consecutive idle cycles: hi/lo updated one edge each, done stays 0.
  - start issued in the done cycle: accepted, busy=1 after the next edge.
  - op=110 with start: no change.
